// File: rtl/rv_pkg.sv
// Shared RV core types: register address/data widths and write-back entry.
// Consumers import rv_pkg::* directly.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_LU
  } gnt_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry valid/ready FIFO for buffered long-latency write-back results.
// Pop is out_valid && out_ready; push is in_valid && in_ready.
module wb_fifo2
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output wb_entry_t out_data
);

  wb_entry_t  mem_q [2];
  wb_entry_t  mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = mem_q[rd_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{'0, '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single write-port arbiter: MEM/WB pipe vs long-latency results, with busy map.
// Define WB_LU_BYPASS_EN to let an lu result skip the empty FIFO.
module wb_port_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_data,
  output logic                  stall_req,
  output logic [31:0]           busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_entry_t             head, lu_ent;
  logic                  head_valid, head_pop;
  logic                  fifo_ready, push_valid;
  logic                  pipe_req, lu_req, bypass_ok;
  gnt_e                  gnt;
  logic [3:0]            cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic [31:0]           busy_q, busy_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  assign pipe_req = pipe_we && pipe_rd != '0;
  assign lu_req   = lu_valid && lu_rd != '0;
  assign lu_ent   = '{rd: lu_rd, data: lu_data};
  assign lu_ready = fifo_ready;

`ifdef WB_LU_BYPASS_EN
  assign bypass_ok = lu_req && !head_valid
                  && !stall_q && !pipe_req;
`else
  assign bypass_ok = 1'b0;
`endif

  // rd=0 results are handshaken but never stored
  assign push_valid = lu_req && !bypass_ok;
  assign head_pop   = gnt == GNT_FIFO;

  wb_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (fifo_ready),
    .in_data   (lu_ent),
    .out_valid (head_valid),
    .out_ready (head_pop),
    .out_data  (head)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (stall_q && head_valid) gnt = GNT_FIFO;
    else if (!stall_q && pipe_req) gnt = GNT_PIPE;
    else if (head_valid) gnt = GNT_FIFO;
    else if (bypass_ok) gnt = GNT_LU;
  end

  always_comb begin
    rf_we_d   = gnt != GNT_NONE;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    unique case (gnt)
      GNT_PIPE: begin
        rf_rd_d   = pipe_rd;
        rf_data_d = pipe_data;
      end
      GNT_FIFO: begin
        rf_rd_d   = head.rd;
        rf_data_d = head.data;
      end
      GNT_LU: begin
        rf_rd_d   = lu_rd;
        rf_data_d = lu_data;
      end
      default: ;
    endcase

    if (!head_valid || head_pop) cnt_d = 4'd0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + 4'd1;
    else cnt_d = cnt_q;

    stall_d = (stall_q || cnt_q == LIMIT) && !head_pop;

    // issue after clear so a same-cycle set wins
    busy_d = busy_q;
    if (gnt == GNT_FIFO || gnt == GNT_LU)
      busy_d[rf_rd_d] = 1'b0;
    if (lu_issue && lu_issue_rd != '0)
      busy_d[lu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      stall_q   <= 1'b0;
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;
  assign stall_req = stall_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall_req;
  logic [31:0] busy;

  int total = 0;
  int bad = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .stall_req   (stall_req),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          wait_n;
  bit          m_stall;
  logic [31:0] m_busy;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic model_clear();
    q.delete();
    wait_n  = 0;
    m_stall = 0;
    m_busy  = '0;
    m_we    = 0;
    m_rd    = '0;
    m_data  = '0;
  endtask

  task automatic idle_inputs();
    pipe_we     = 0;
    pipe_rd     = '0;
    pipe_data   = '0;
    lu_valid    = 0;
    lu_rd       = '0;
    lu_data     = '0;
    lu_issue    = 0;
    lu_issue_rd = '0;
  endtask

  // One clock: evaluate the rules on current inputs, advance, update model.
  task automatic tick();
    int          g;
    bit          acc, byp_en, n_stall;
    int          n_wait;
    logic [31:0] n_busy;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    ent_t        e;
`ifdef WB_LU_BYPASS_EN
    byp_en = 1;
`else
    byp_en = 0;
`endif
    acc = lu_valid && q.size() < 2 && lu_rd != 0;
    e = '{rd: lu_rd, data: lu_data};
    g = 0;
    if (m_stall && q.size() > 0) g = 2;
    else if (!m_stall && pipe_we && pipe_rd != 0) g = 1;
    else if (q.size() > 0) g = 2;
    else if (byp_en && acc) g = 3;
    if (q.size() == 0 || g == 2) n_wait = 0;
    else n_wait = (wait_n < LIM) ? wait_n + 1 : LIM;
    n_stall = (m_stall || wait_n == LIM) && g != 2;
    n_rd = m_rd;
    n_data = m_data;
    if (g == 1) begin
      n_rd = pipe_rd;
      n_data = pipe_data;
    end else if (g == 2) begin
      n_rd = q[0].rd;
      n_data = q[0].data;
    end else if (g == 3) begin
      n_rd = lu_rd;
      n_data = lu_data;
    end
    n_busy = m_busy;
    if (g >= 2) n_busy[n_rd] = 1'b0;
    if (lu_issue && lu_issue_rd != 0)
      n_busy[lu_issue_rd] = 1'b1;
    n_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    if (g == 2) void'(q.pop_front());
    if (acc && g != 3) q.push_back(e);
    wait_n  = n_wait;
    m_stall = n_stall;
    m_busy  = n_busy;
    m_we    = (g != 0);
    m_rd    = n_rd;
    m_data  = n_data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    total++;
    if (rf_we !== 1'b0 || stall_req !== 1'b0
        || busy !== 32'h0 || lu_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: we=%b stall=%b busy=%h rdy=%b want 0 0 0 1",
               rf_we, stall_req, busy, lu_ready);
    end
    do_reset();
  endtask

  task automatic test_pipe_write();
    do_reset();
    pipe_we = 1;
    pipe_rd = 5'd5;
    pipe_data = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    total++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5
        || rf_data !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL pipe_write: we=%b rd=%0d data=%h want 1 5 a5a5a5a5",
               rf_we, rf_rd, rf_data);
    end
    tick();
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL pipe_idle: we=%b want 0", rf_we);
    end
  endtask

  task automatic test_starve();
    int n;
    bit seen;
    do_reset();
    lu_valid = 1;
    lu_rd = 5'd7;
    lu_data = 32'h11;
    pipe_we = 1;
    pipe_rd = 5'(10 + $urandom_range(0, 20));
    pipe_data = $urandom;
    tick();
    lu_valid = 0;
    n = 1;
    seen = 0;
    while (!seen && n < 20) begin
      if (stall_req === 1'b1) begin
        seen = 1;
      end else begin
        pipe_rd = 5'(10 + $urandom_range(0, 20));
        pipe_data = $urandom;
        tick();
        n++;
        total++;
        if (stall_req !== m_stall || rf_rd !== m_rd) begin
          bad++;
          $display("FAIL starve_step: stall=%b rd=%0d want %b %0d",
                   stall_req, rf_rd, m_stall, m_rd);
        end
      end
    end
    total++;
    if (!seen || n != LIM + 2) begin
      bad++;
      $display("FAIL starve_time: cycles=%0d seen=%b want %0d 1",
               n, seen, LIM + 2);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7
        || rf_data !== 32'h11 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL starve_grant: we=%b rd=%0d data=%h stall=%b want 1 7 11 0",
               rf_we, rf_rd, rf_data, stall_req);
    end
    idle_inputs();
    tick();
    total++;
    if (rf_we !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL starve_after: we=%b stall=%b want 0 0",
               rf_we, stall_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] rds [3];
    int got[$];
    rds[0] = 5'd3;
    rds[1] = 5'd4;
    rds[2] = 5'd6;
    do_reset();
    pipe_we = 1;
    for (int i = 0; i < 3; i++) begin
      pipe_rd = 5'(10 + $urandom_range(0, 20));
      pipe_data = $urandom;
      lu_valid = 1;
      lu_rd = rds[i];
      lu_data = 32'hC0DE_0000 + 32'(i);
      total++;
      if (lu_ready !== (i < 2)) begin
        bad++;
        $display("FAIL b2b_ready%0d: got %b want %b",
                 i, lu_ready, i < 2);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we === 1'b1) begin
        got.push_back(int'(rf_rd));
        if (rf_data !== 32'hC0DE_0000 + 32'(got.size() - 1)) begin
          bad++;
          $display("FAIL b2b_data: got %h", rf_data);
        end
        total++;
      end
    end
    total++;
    if (got.size() != 2 || got[0] != 3 || got[1] != 4) begin
      bad++;
      $display("FAIL b2b_order: n=%0d want 2 writes rd 3 then 4",
               got.size());
    end
  endtask

  task automatic test_busy();
    do_reset();
    lu_issue = 1;
    lu_issue_rd = 5'd9;
    tick();
    idle_inputs();
    total++;
    if (busy[9] !== 1'b1) begin
      bad++;
      $display("FAIL busy_set: got %b want 1", busy[9]);
    end
    lu_valid = 1;
    lu_rd = 5'd9;
    lu_data = 32'h99;
    tick();
    idle_inputs();
    repeat (2) tick();
    total++;
    if (busy[9] !== 1'b0) begin
      bad++;
      $display("FAIL busy_clear: got %b want 0", busy[9]);
    end
    lu_issue = 1;
    lu_issue_rd = 5'd9;
    tick();
    lu_valid = 1;
    lu_rd = 5'd9;
    lu_data = 32'h98;
`ifdef WB_LU_BYPASS_EN
    lu_issue = 1;
`else
    lu_issue = 0;
    tick();
    lu_valid = 0;
    lu_issue = 1;
`endif
    tick();
    idle_inputs();
    total++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd9 || busy[9] !== 1'b1) begin
      bad++;
      $display("FAIL busy_setwins: we=%b rd=%0d busy9=%b want 1 9 1",
               rf_we, rf_rd, busy[9]);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    pipe_we = 1;
    pipe_rd = 5'd0;
    pipe_data = $urandom;
    lu_valid = 1;
    lu_rd = 5'd0;
    lu_data = $urandom;
    lu_issue = 1;
    lu_issue_rd = 5'd0;
    tick();
    idle_inputs();
    total++;
    if (rf_we !== 1'b0 || busy !== 32'h0 || lu_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_zero: we=%b busy=%h rdy=%b want 0 0 1",
               rf_we, busy, lu_ready);
    end
    tick();
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL rd_zero_fifo: we=%b want 0", rf_we);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pipe_we = 1;
    for (int i = 0; i < 2; i++) begin
      pipe_rd = 5'd20;
      pipe_data = $urandom;
      lu_valid = 1;
      lu_rd = 5'(12 + i);
      lu_data = $urandom;
      lu_issue = 1;
      lu_issue_rd = 5'(12 + i);
      tick();
    end
    idle_inputs();
    total++;
    if (lu_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: rdy=%b want 0", lu_ready);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0
        || busy !== 32'h0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b we=%b busy=%h stall=%b want 1 0 0 0",
               lu_ready, rf_we, busy, stall_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (rf_we !== 1'b0) begin
        bad++;
        $display("FAIL mid_after%0d: we=%b want 0", i, rf_we);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        pipe_we = ($urandom_range(0, 99) < 60);
        pipe_rd = 5'($urandom_range(0, 31));
        pipe_data = $urandom;
      end
      lu_valid = ($urandom_range(0, 99) < 35);
      lu_rd = 5'($urandom_range(0, 31));
      lu_data = $urandom;
      lu_issue = ($urandom_range(0, 99) < 30);
      lu_issue_rd = 5'($urandom_range(0, 31));
      total++;
      if (lu_ready !== (q.size() < 2)) begin
        bad++;
        $display("FAIL rnd_ready@%0d: got %b want %b",
                 i, lu_ready, q.size() < 2);
      end
      tick();
      total++;
      if (rf_we !== m_we || stall_req !== m_stall || busy !== m_busy
          || (m_we && (rf_rd !== m_rd || rf_data !== m_data))) begin
        bad++;
        $display("FAIL rnd@%0d: we=%b rd=%0d d=%h st=%b bz=%h want %b %0d %h %b %h",
                 i, rf_we, rf_rd, rf_data, stall_req, busy,
                 m_we, m_rd, m_data, m_stall, m_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_starve();
    test_back_to_back();
    test_busy();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
